// File: rtl/vga_sync_decoder_pkg.sv
// ---------------------------------------------------------------------------
// vga_timing_pkg
// Shared VGA timing constants, the coordinate type and the decoder state
// encoding used by the sync decoder and its edge detector.
// ---------------------------------------------------------------------------
package vga_timing_pkg;

  // Nominal geometry (pixel clocks per line, lines per frame)
  localparam int H_TOTAL_C        = 800;
  localparam int H_ACTIVE_C       = 640;
  localparam int H_SYNC_START_C   = 657;
  localparam int H_SYNC_WIDTH_C   = 96;
  localparam int V_TOTAL_C        = 526;
  localparam int V_ACTIVE_C       = 480;
  localparam int V_SYNC_START_C   = 491;
  localparam int V_SYNC_WIDTH_C   = 2;

  // Counter values loaded on the edge that registers a detected sync fall:
  // sync start + 1 source register + 2 synchronizer stages.
  localparam int H_ANCHOR_C       = 660;
  localparam int V_ANCHOR_C       = 491;

  localparam int SYNC_STAGES_C    = 2;
  localparam int LOCK_LINES_C     = 4;

  typedef logic [9:0] coord_t;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    H_TRACK = 2'd1,
    V_WAIT  = 2'd2,
    LOCKED  = 2'd3
  } dec_state_t;

  // Modulo increment of a 10-bit coordinate.
  function automatic coord_t wrap_inc(input coord_t value, input coord_t last);
    return (value == last) ? '0 : value + coord_t'(1);
  endfunction

endpackage

// File: rtl/vga_sync_decoder_sync_edge_detect.sv
// ---------------------------------------------------------------------------
// sync_edge_detect
// Multi-flop synchronizer for one asynchronous active-low sync pin plus a
// falling-edge pulse taken from the last stage and its previous value.
// Flops reset to 1 (idle sync level). Input-to-pulse latency is STAGES+1.
//
// Ports:
//   clk      in   pixel clock
//   rst_n    in   asynchronous active-low reset
//   i_async  in   raw sync pin
//   o_fall   out  one-cycle pulse, combinational from registered samples
// ---------------------------------------------------------------------------
module sync_edge_detect #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_fall
);

  logic [STAGES-1:0] r_sync;
  logic              r_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '1;
      r_prev <= 1'b1;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_async};
      r_prev <= r_sync[STAGES-1];
    end
  end

  assign o_fall = r_prev & ~r_sync[STAGES-1];

endmodule

// File: rtl/vga_sync_decoder.sv
// ---------------------------------------------------------------------------
// vga_sync_decoder
// Rebuilds pixel coordinates and a display-area flag from active-low
// hsync/vsync pins, locks to the incoming timing and flags any deviation
// from the nominal geometry.
//
// Ports:
//   clk          in   pixel clock
//   rst_n        in   asynchronous active-low reset
//   vga_h_sync   in   horizontal sync, active low
//   vga_v_sync   in   vertical sync, active low
//   pix_x        out  reconstructed column
//   pix_y        out  reconstructed row
//   in_display   out  locked and inside the visible area (registered)
//   locked       out  high only in LOCKED
//   frame_start  out  pulse when locked coordinates become (0,0)
//   sync_err     out  pulse on a timing mismatch in V_WAIT or LOCKED
// ---------------------------------------------------------------------------
module vga_sync_decoder
  import vga_timing_pkg::*;
#(
  parameter int H_TOTAL     = H_TOTAL_C,
  parameter int H_ACTIVE    = H_ACTIVE_C,
  parameter int V_TOTAL     = V_TOTAL_C,
  parameter int V_ACTIVE    = V_ACTIVE_C,
  parameter int H_ANCHOR    = H_ANCHOR_C,
  parameter int V_ANCHOR    = V_ANCHOR_C,
  parameter int SYNC_STAGES = SYNC_STAGES_C,
  parameter int LOCK_LINES  = LOCK_LINES_C
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   vga_h_sync,
  input  logic   vga_v_sync,
  output coord_t pix_x,
  output coord_t pix_y,
  output logic   in_display,
  output logic   locked,
  output logic   frame_start,
  output logic   sync_err
);

  localparam int     GW      = $clog2(LOCK_LINES + 1);
  localparam coord_t H_LAST  = coord_t'(H_TOTAL - 1);
  localparam coord_t V_LAST  = coord_t'(V_TOTAL - 1);
  localparam coord_t H_ACT   = coord_t'(H_ACTIVE);
  localparam coord_t V_ACT   = coord_t'(V_ACTIVE);
  localparam coord_t H_ANC   = coord_t'(H_ANCHOR);
  localparam coord_t V_ANC   = coord_t'(V_ANCHOR);
  localparam coord_t V_AFTER = coord_t'(V_ANCHOR + 1);

  dec_state_t    r_state, w_state_next;
  coord_t        r_pix_x, r_pix_y;
  logic [GW-1:0] r_good_cnt, w_good_next;
  logic          r_vs_seen, w_vs_seen_next;
  logic          r_in_display, r_frame_start, r_sync_err;

  logic   w_hs_fall, w_vs_fall;
  logic   w_x_wrap, w_h_ok, w_h_bad, w_err;
  coord_t w_x_free, w_y_free, w_x_next, w_y_next;

  sync_edge_detect #(.STAGES(SYNC_STAGES)) u_hs_detect (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_async (vga_h_sync),
    .o_fall  (w_hs_fall)
  );

  sync_edge_detect #(.STAGES(SYNC_STAGES)) u_vs_detect (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_async (vga_v_sync),
    .o_fall  (w_vs_fall)
  );

  // Free-running successors; every check compares against these values.
  assign w_x_wrap = (r_pix_x == H_LAST);
  assign w_x_free = wrap_inc(r_pix_x, H_LAST);
  assign w_y_free = w_x_wrap ? wrap_inc(r_pix_y, V_LAST) : r_pix_y;
  assign w_h_ok   = (w_x_free == H_ANC);
  // Either an hsync at the wrong column or no hsync where one was due.
  assign w_h_bad  = w_hs_fall ? !w_h_ok : w_h_ok;

  always_comb begin
    w_state_next   = r_state;
    w_x_next       = w_hs_fall ? H_ANC : w_x_free;
    w_y_next       = w_vs_fall ? V_ANC : w_y_free;
    w_good_next    = r_good_cnt;
    w_vs_seen_next = r_vs_seen;
    w_err          = 1'b0;

    if (w_x_wrap && (w_y_free == '0)) begin
      w_vs_seen_next = 1'b0;
    end

    unique case (r_state)
      HUNT: begin
        w_x_next       = '0;
        w_y_next       = '0;
        w_good_next    = '0;
        w_vs_seen_next = 1'b0;
        if (w_hs_fall) begin
          w_x_next     = H_ANC;
          w_state_next = H_TRACK;
        end
      end
      H_TRACK: begin
        if (w_h_bad) begin
          w_good_next = '0;
        end else if (w_hs_fall) begin
          w_good_next = r_good_cnt + GW'(1);
          if (r_good_cnt == GW'(LOCK_LINES - 1)) begin
            w_state_next = V_WAIT;
          end
        end
      end
      V_WAIT: begin
        if (w_h_bad) begin
          w_err = 1'b1;
        end else if (w_vs_fall) begin
          w_vs_seen_next = 1'b1;
          w_state_next   = LOCKED;
        end
      end
      LOCKED: begin
        // Horizontal check has priority so a combined fault pulses once.
        if (w_h_bad) begin
          w_err = 1'b1;
        end else if (w_vs_fall) begin
          if (w_y_free != V_ANC) begin
            w_err = 1'b1;
          end else begin
            w_vs_seen_next = 1'b1;
          end
        end else if (w_x_wrap && (w_y_free == V_AFTER) && !r_vs_seen) begin
          w_err = 1'b1;
        end
      end
      default: w_state_next = HUNT;
    endcase

    if (w_err) begin
      w_state_next   = HUNT;
      w_x_next       = '0;
      w_y_next       = '0;
      w_good_next    = '0;
      w_vs_seen_next = 1'b0;
    end
  end

  // Outputs are registered from next-state values so they line up with the
  // coordinates and drop on the same edge the FSM leaves LOCKED.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= HUNT;
      r_pix_x       <= '0;
      r_pix_y       <= '0;
      r_good_cnt    <= '0;
      r_vs_seen     <= 1'b0;
      r_in_display  <= 1'b0;
      r_frame_start <= 1'b0;
      r_sync_err    <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_pix_x       <= w_x_next;
      r_pix_y       <= w_y_next;
      r_good_cnt    <= w_good_next;
      r_vs_seen     <= w_vs_seen_next;
      r_in_display  <= (w_state_next == LOCKED) && (w_x_next < H_ACT) && (w_y_next < V_ACT);
      r_frame_start <= (r_state == LOCKED) && (w_state_next == LOCKED) &&
                       (w_x_next == '0) && (w_y_next == '0);
      r_sync_err    <= w_err;
    end
  end

  assign pix_x       = r_pix_x;
  assign pix_y       = r_pix_y;
  assign in_display  = r_in_display;
  assign locked      = (r_state == LOCKED);
  assign frame_start = r_frame_start;
  assign sync_err    = r_sync_err;

endmodule

// File: doc/vga_sync_decoder.md
Name: vga_sync_decoder

Overview:
- Display-side counterpart of the VGA sync generator: takes active-low hsync/vsync pins and rebuilds pixel coordinates and a display-area flag locally.
- Locks to the incoming timing, checks every line and frame against the nominal geometry, and reports loss of lock.
- Serves frame capture, on-chip self-check of the video path, and as a scoreboard source in benches.

Parameters:
- H_TOTAL, 800, clocks per line.
- H_ACTIVE, 640, visible pixels per line.
- V_TOTAL, 526, lines per frame.
- V_ACTIVE, 480, visible lines per frame.
- H_ANCHOR, 660, value pix_x takes on the edge that registers a detected hsync fall (657 sync start + 1 source register + 2 sync stages).
- V_ANCHOR, 491, value pix_y takes on the edge that registers a detected vsync fall.
- SYNC_STAGES, 2, synchronizer flops per sync input (≥2).
- LOCK_LINES, 4, consecutive correct-length lines required for horizontal lock.

Ports:
- clk  in  1  pixel clock.
- rst_n  in  1  asynchronous active-low reset.
- vga_h_sync  in  1  horizontal sync, active low.
- vga_v_sync  in  1  vertical sync, active low.
- pix_x  out  10  reconstructed column.
- pix_y  out  10  reconstructed row.
- in_display  out  1  registered; locked && pix_x<H_ACTIVE && pix_y<V_ACTIVE.
- locked  out  1  high only in LOCKED.
- frame_start  out  1  one-cycle pulse when LOCKED and (pix_x,pix_y) becomes (0,0).
- sync_err  out  1  one-cycle pulse on any timing mismatch while in V_WAIT or LOCKED.

Behaviour:
- Interface: one clock, clk; reset rst_n is asynchronous and active-low. On reset all outputs are 0, synchronizer flops are 1 (idle), FSM = HUNT, and good_cnt and vs_seen are 0.
- Edge detect:
  - hs_fall = last sync stage 0 while the previous sample was 1; vs_fall is the same for vsync.
  - Both are combinational from registered samples.
  - Input-to-detect latency is SYNC_STAGES+1 clocks.
- Counters:
  - Free-run: pix_x wraps from H_TOTAL-1 to 0. pix_y increments on that wrap and wraps from V_TOTAL-1 to 0.
  - An hs_fall loads pix_x<=H_ANCHOR. A vs_fall loads pix_y<=V_ANCHOR; pix_x is not touched.
  - In HUNT both counters are held at 0.
  - All arithmetic is unsigned 10-bit. Parameters must satisfy H_TOTAL, V_TOTAL ≤ 1024.
- Line check: "h_ok" means the free-run next value of pix_x equals H_ANCHOR. "h_miss" means that next value equals H_ANCHOR with no hs_fall in that cycle.
- FSM:
  - HUNT: on hs_fall, load pix_x, set good_cnt=0, go to H_TRACK.
  - H_TRACK:
    - hs_fall with h_ok: good_cnt++.
    - hs_fall without h_ok, or h_miss: good_cnt=0 and pix_x reloads (or free-runs, on h_miss).
    - When good_cnt reaches LOCK_LINES, go to V_WAIT. No sync_err is raised in this state.
  - V_WAIT:
    - vs_fall: load pix_y, set vs_seen=1, go to LOCKED.
    - A horizontal mismatch or h_miss: pulse sync_err, go to HUNT.
  - LOCKED:
    - hs_fall without h_ok, or h_miss: sync_err, go to HUNT.
    - vs_fall with pix_y≠V_ANCHOR (pre-load free-run value): sync_err, go to HUNT.
    - A pix_y increment to V_ANCHOR+1 while vs_seen=0: sync_err, go to HUNT.
    - vs_seen is cleared when pix_y wraps to 0.
- Simultaneous hs_fall and vs_fall: both loads apply in the same cycle. The horizontal check is evaluated first; any single error gives one sync_err pulse, never two.
- Leaving LOCKED: locked and in_display drop on the same edge the FSM leaves; counters are zeroed on entry to HUNT.
- Reset mid-frame: immediate return to the reset values; relock from scratch.

Decomposition:
- Package vga_timing_pkg:
  - 800/640/526/480 geometry constants and the sync start/width constants.
  - typedef coord_t (logic [9:0]).
  - Enum dec_state_t {HUNT, H_TRACK, V_WAIT, LOCKED}.
- Sub-module sync_edge_detect: parameterised synchronizer plus falling-edge pulse, instantiated twice.

Test Plan:
- Nominal 800×526 stream from the generator model:
  - locked rises on the first vs_fall after 4 good lines.
  - From then on, pix_x==660 in the cycle after every hs_fall, with period 800.
  - Exactly 307200 in_display cycles per frame.
  - One frame_start per 420800 clocks.
- Stretch one line to 801 clocks while LOCKED: exactly one sync_err pulse, locked=0 on the same edge, counters 0, relock after 4 good lines plus the next vsync.
- Suppress one vsync pulse: sync_err when pix_y steps to 492, FSM in HUNT.
- Glitch hsync low for 1 clock in H_TRACK (bad length): good_cnt resets, no sync_err, lock delayed by the extra lines.
- Force coincident hs_fall and vs_fall at pix_y=491 in LOCKED: pix_x=660 and pix_y=491 loaded together, no error; repeat with pix_y=400: a single sync_err pulse.
- Assert rst_n low mid-frame for 3 clocks: all outputs 0 within the reset window, syncs read idle, relock as in the nominal case.
